// File: rtl/data_ram_ctrl_pkg.sv
// Shared constants, FSM encoding and request payload for the data-memory controller.
package data_ram_ctrl_pkg;

  localparam int unsigned RegBus = 32;
  localparam int unsigned SelW   = RegBus / 8;
  localparam int unsigned CntW   = 4;

  localparam logic ChipEnable  = 1'b1;
  localparam logic WriteEnable = 1'b1;

  typedef enum logic [1:0] {
    RamIdle = 2'd0,
    RamWait = 2'd1,
    RamDone = 2'd2
  } ram_state_e;

  typedef struct packed {
    logic              we;
    logic [SelW-1:0]   sel;
    logic [RegBus-1:0] wdata;
  } ram_req_t;

endpackage

// File: rtl/data_ram_array.sv
// Single-port word array with byte-lane write enables and a registered read port.
module data_ram_array
  import data_ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [SelW-1:0]   i_sel,
  input  logic [ADDR_W-1:0] i_idx,
  input  logic [RegBus-1:0] i_wdata,
  output logic [RegBus-1:0] o_rdata
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [RegBus-1:0] r_mem [Depth];
  logic [RegBus-1:0] r_rdata;

  // Storage has no reset: contents survive a controller reset.
  always_ff @(posedge i_clk) begin : p_write
    if (i_en && (i_we == WriteEnable)) begin
      for (int unsigned b = 0; b < SelW; b++) begin
        if (i_sel[b]) begin
          r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read register holds its value until the next read access.
  always_ff @(posedge i_clk or negedge i_rst_n) begin : p_read
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_en && (i_we != WriteEnable)) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_ram_ctrl.sv
// Multi-cycle data-memory controller: latches a cache request, waits LATENCY edges,
// performs the access and returns a one-cycle ready pulse.
module data_ram_ctrl
  import data_ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_ce,
  input  logic              ram_we,
  input  logic [SelW-1:0]   ram_sel,
  input  logic [RegBus-1:0] ram_addr,
  input  logic [RegBus-1:0] ram_wdata,
  output logic [RegBus-1:0] ram_rdata,
  output logic              ram_data_ready,
  output logic              busy
);

  ram_state_e        r_state;
  ram_state_e        w_state_nxt;
  logic [CntW-1:0]   r_cnt;
  ram_req_t          r_req;
  logic [ADDR_W-1:0] r_idx;
  logic              r_ready;
  logic              r_busy;
  logic              w_accept;
  logic              w_access;
  logic              w_ready_nxt;
  logic              w_busy_nxt;
  logic              w_unused_addr;

  // Byte offset and bits above the word index never select storage.
  assign w_unused_addr = ^{ram_addr[RegBus-1:ADDR_W+2], ram_addr[1:0]};

  always_ff @(posedge clk or negedge rst) begin : p_state
    if (!rst) begin
      r_state <= RamIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin : p_next
    w_state_nxt = r_state;
    unique case (r_state)
      RamIdle: if (ram_ce == ChipEnable) w_state_nxt = RamWait;
      RamWait: if (r_cnt == '0) w_state_nxt = RamDone;
      RamDone: w_state_nxt = RamIdle;
      default: w_state_nxt = RamIdle;
    endcase
  end

  always_comb begin : p_out
    w_accept    = 1'b0;
    w_access    = 1'b0;
    w_ready_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    w_accept    = (r_state == RamIdle) && (ram_ce == ChipEnable);
    w_access    = (r_state == RamWait) && (r_cnt == '0);
    w_ready_nxt = (w_state_nxt == RamDone);
    w_busy_nxt  = (w_state_nxt != RamIdle);
  end

  // Request latch, wait-state counter and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin : p_dp
    if (!rst) begin
      r_cnt   <= '0;
      r_req   <= '0;
      r_idx   <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      if (w_accept) begin
        r_cnt <= CntW'(LATENCY - 1);
        r_idx <= ram_addr[ADDR_W+1:2];
        r_req <= '{we: ram_we, sel: ram_sel, wdata: ram_wdata};
      end else if ((r_state == RamWait) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CntW'(1);
      end
    end
  end

  data_ram_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .i_clk  (clk),
    .i_rst_n(rst),
    .i_en   (w_access),
    .i_we   (r_req.we),
    .i_sel  (r_req.sel),
    .i_idx  (r_idx),
    .i_wdata(r_req.wdata),
    .o_rdata(ram_rdata)
  );

  assign ram_data_ready = r_ready;
  assign busy           = r_busy;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Bench for data_ram_ctrl: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-timing model.
module tb_data_ram_ctrl;

  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int          L0    = 3;
  localparam int          L1    = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        ce0 = 1'b0, we0 = 1'b0;
  logic [3:0]  sel0 = '0;
  logic [31:0] addr0 = '0, wd0 = '0;
  logic [31:0] rd0;
  logic        rdy0, bsy0;

  logic        ce1 = 1'b0, we1 = 1'b0;
  logic [3:0]  sel1 = '0;
  logic [31:0] addr1 = '0, wd1 = '0;
  logic [31:0] rd1;
  logic        rdy1, bsy1;

  always #5 clk = ~clk;

  data_ram_ctrl #(.ADDR_W(AW), .LATENCY(L0)) u_dut0 (
    .clk(clk), .rst(rst), .ram_ce(ce0), .ram_we(we0), .ram_sel(sel0),
    .ram_addr(addr0), .ram_wdata(wd0), .ram_rdata(rd0),
    .ram_data_ready(rdy0), .busy(bsy0)
  );

  data_ram_ctrl #(.ADDR_W(AW), .LATENCY(L1)) u_dut1 (
    .clk(clk), .rst(rst), .ram_ce(ce1), .ram_we(we1), .ram_sel(sel1),
    .ram_addr(addr1), .ram_wdata(wd1), .ram_rdata(rd1),
    .ram_data_ready(rdy1), .busy(bsy1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the LATENCY=3 instance: per-byte known tracking plus edge-count timing.
  logic [31:0] m_mem [DEPTH];
  logic [3:0]  m_kn  [DEPTH];
  int          e = 0, m_t0 = 0, m_free = 0;
  bit          m_act = 1'b0;
  logic        m_we;
  logic [3:0]  m_sel;
  logic [AW-1:0] m_idx;
  logic [31:0] m_wd;
  logic [31:0] x_rdata = '0;
  bit          x_rd_known = 1'b1;
  bit          x_ready = 1'b0, x_busy = 1'b0;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_kn[i]  = '0;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_act = 1'b0; m_free = 0;
      x_rdata = '0; x_rd_known = 1'b1; x_ready = 1'b0; x_busy = 1'b0;
    end else begin
      e++;
      if (m_act && (e == m_t0 + L0)) begin
        if (m_we) begin
          for (int b = 0; b < 4; b++) begin
            if (m_sel[b]) begin
              m_mem[m_idx][8*b +: 8] = m_wd[8*b +: 8];
              m_kn[m_idx][b] = 1'b1;
            end
          end
        end else begin
          x_rdata    = m_mem[m_idx];
          x_rd_known = (m_kn[m_idx] == 4'hF);
        end
      end
      if (ce0 && (e >= m_free)) begin
        m_act = 1'b1; m_t0 = e; m_free = e + L0 + 2;
        m_we = we0; m_sel = sel0; m_idx = addr0[AW+1:2]; m_wd = wd0;
      end
      x_ready = m_act && (e == m_t0 + L0);
      x_busy  = m_act && (e >= m_t0) && (e <= m_t0 + L0);
    end
  end

  always @(negedge clk) begin
    check("ready", 32'(rdy0), 32'(x_ready));
    check("busy", 32'(bsy0), 32'(x_busy));
    if (x_rd_known) check("rdata", rd0, x_rdata);
  end

  // One request on instance inst; returns edges from accept to ready and the read data.
  task automatic req(input int inst, input logic w, input logic [3:0] s,
                     input logic [31:0] a, input logic [31:0] d,
                     output int lat, output logic [31:0] rd);
    @(negedge clk);
    if (inst == 0) begin ce0 = 1'b1; we0 = w; sel0 = s; addr0 = a; wd0 = d; end
    else begin ce1 = 1'b1; we1 = w; sel1 = s; addr1 = a; wd1 = d; end
    @(posedge clk);
    @(negedge clk);
    if (inst == 0) ce0 = 1'b0; else ce1 = 1'b0;
    lat = 0;
    while ((((inst == 0) ? rdy0 : rdy1) == 1'b0) && (lat < 40)) begin
      @(negedge clk);
      lat++;
    end
    rd = (inst == 0) ? rd0 : rd1;
    if (lat >= 40) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: got no ready within %0d edges, expected one", lat);
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    int          npulse, k_first, k_second;
    logic [31:0] rd_second;

    repeat (3) @(negedge clk);
    check("reset_rdata", rd0, 32'h0);
    check("reset_ready", 32'(rdy0), 32'h0);
    check("reset_busy", 32'(bsy0), 32'h0);
    check("reset_rdata_l1", rd1, 32'h0);
    #2 rst = 1'b1;

    req(0, 1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, lat, rd);
    check("wr_latency", 32'(lat), 32'd3);
    req(0, 1'b0, 4'hF, 32'h0000_0100, 32'h0, lat, rd);
    check("rd_latency", 32'(lat), 32'd3);
    check("rd_0x100", rd, 32'hDEAD_BEEF);

    req(0, 1'b1, 4'hF, 32'h0000_0040, 32'h1122_3344, lat, rd);
    req(0, 1'b1, 4'h5, 32'h0000_0040, 32'hAABB_CCDD, lat, rd);
    req(0, 1'b0, 4'h0, 32'h0000_0040, 32'h0, lat, rd);
    check("byte_lanes", rd, 32'h11BB_33DD);

    req(0, 1'b1, 4'hF, 32'h0000_4004, 32'h5A5A_5A5A, lat, rd);
    req(0, 1'b0, 4'hF, 32'h0000_0004, 32'h0, lat, rd);
    check("alias_rd", rd, 32'h5A5A_5A5A);
    req(0, 1'b0, 4'hF, 32'h0000_0007, 32'h0, lat, rd);
    check("alias_rd_b11", rd, 32'h5A5A_5A5A);

    // Back-to-back: ce held high, address changed after the first accept.
    @(negedge clk);
    ce0 = 1'b1; we0 = 1'b0; sel0 = 4'hF; addr0 = 32'h0000_0100;
    npulse = 0; k_first = -1; k_second = -1; rd_second = '0;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (rdy0) begin
        npulse++;
        if (k_first < 0) k_first = k;
        else begin k_second = k; rd_second = rd0; end
      end
      if (k == 0) addr0 = 32'h0000_0040;
      if (k == 5) ce0 = 1'b0;
    end
    check("b2b_pulses", 32'(npulse), 32'd2);
    check("b2b_first", 32'(k_first), 32'd3);
    check("b2b_spacing", 32'(k_second - k_first), 32'(L0 + 2));
    check("b2b_rdata", rd_second, 32'h11BB_33DD);

    // Reset one cycle into a write must abort it.
    req(0, 1'b1, 4'hF, 32'h0000_0200, 32'h0, lat, rd);
    @(negedge clk);
    ce0 = 1'b1; we0 = 1'b1; sel0 = 4'hF; addr0 = 32'h0000_0200; wd0 = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    ce0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_ready", 32'(rdy0), 32'h0);
    check("rst_busy", 32'(bsy0), 32'h0);
    check("rst_rdata", rd0, 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    req(0, 1'b0, 4'hF, 32'h0000_0200, 32'h0, lat, rd);
    check("rst_abort_mem", rd, 32'h0);

    // LATENCY=1 instance, including an empty-lane write.
    req(1, 1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678, lat, rd);
    check("l1_wr_latency", 32'(lat), 32'd1);
    req(1, 1'b1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, lat, rd);
    check("l1_sel0_latency", 32'(lat), 32'd1);
    req(1, 1'b0, 4'hF, 32'h0000_0010, 32'h0, lat, rd);
    check("l1_rd_latency", 32'(lat), 32'd1);
    check("l1_sel0_unchanged", rd, 32'h1234_5678);

    // Random traffic on the LATENCY=3 instance with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      ce0   = ($urandom_range(3) != 0);
      we0   = 1'($urandom_range(1));
      sel0  = 4'($urandom_range(15));
      wd0   = $urandom;
      addr0 = ($urandom & 32'hFFFF_C000) | (32'(12'h0C0 + 12'($urandom_range(15))) << 2)
              | 32'($urandom_range(3));
      if (rst == 1'b0) #2 rst = 1'b1;
      else if ($urandom_range(299) == 0) #2 rst = 1'b0;
    end
    @(negedge clk);
    ce0 = 1'b0;
    if (rst == 1'b0) #2 rst = 1'b1;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
